// File: rtl/sext_pkg.sv
// Shared types and field widths for the LC-3 sign/zero-extension stage.
package sext_pkg;

   // Field-select codes; values 5..7 are left undefined and treated as illegal.
   typedef enum logic [2:0] {
      SEXT5  = 3'd0,
      SEXT6  = 3'd1,
      SEXT9  = 3'd2,
      SEXT11 = 3'd3,
      ZEXT8  = 3'd4
   } ext_sel_t;

   // Widths of the instruction fields each select code extracts.
   localparam int SEXT5_W  = 5;
   localparam int SEXT6_W  = 6;
   localparam int SEXT9_W  = 9;
   localparam int SEXT11_W = 11;
   localparam int ZEXT8_W  = 8;

   // Occupancy of the output/skid pair, encoded as {outValid, skidValid}.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'b00,
      OCC_ONE   = 2'b10,
      OCC_FULL  = 2'b11
   } occ_t;

endpackage

// File: rtl/sext_field.sv
// Combinational extender: widens an IN_W-bit field to OUT_W bits, either
// replicating the field MSB (SIGNED=1) or filling with zeros (SIGNED=0).
module sext_field #(
   parameter int IN_W   = 5,
   parameter int OUT_W  = 16,
   parameter bit SIGNED = 1'b1
) (
   input  logic [IN_W-1:0]  field_i,
   output logic [OUT_W-1:0] ext_o
);

   localparam int FILL_W = OUT_W - IN_W;

   logic fillBit;

   assign fillBit = SIGNED ? field_i[IN_W-1] : 1'b0;
   assign ext_o   = {{FILL_W{fillBit}}, field_i};

endmodule

// File: rtl/sext_pipe.sv
// Registered sign/zero-extension stage with a valid/ready handshake and a
// one-entry skid buffer, so InReady depends only on registered state.
module sext_pipe
   import sext_pkg::*;
#(
   parameter int WORD_W = 16,
   parameter int IR_W   = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [IR_W-1:0]   IR,
   input  ext_sel_t          Sel,
   input  logic              InValid,
   output logic              InReady,
   output logic [WORD_W-1:0] DataOut,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              SelErr
);

   logic [WORD_W-1:0] ext5;
   logic [WORD_W-1:0] ext6;
   logic [WORD_W-1:0] ext9;
   logic [WORD_W-1:0] ext11;
   logic [WORD_W-1:0] ext8;

   logic [WORD_W-1:0] newData;
   logic              newErr;

   logic              accept;
   logic              drain;

   occ_t              state_q;
   occ_t              state_d;
   logic [WORD_W-1:0] outData_q;
   logic [WORD_W-1:0] outData_d;
   logic              outErr_q;
   logic              outErr_d;
   logic [WORD_W-1:0] skidData_q;
   logic [WORD_W-1:0] skidData_d;
   logic              skidErr_q;
   logic              skidErr_d;

   // Only the low 11 bits of IR carry fields; the rest are intentionally ignored.
   logic [IR_W-1:0]   unusedIrBits;
   assign unusedIrBits = IR;

   sext_field #(.IN_W(SEXT5_W), .OUT_W(WORD_W), .SIGNED(1'b1)) uExt5 (
      .field_i (IR[SEXT5_W-1:0]),
      .ext_o   (ext5)
   );

   sext_field #(.IN_W(SEXT6_W), .OUT_W(WORD_W), .SIGNED(1'b1)) uExt6 (
      .field_i (IR[SEXT6_W-1:0]),
      .ext_o   (ext6)
   );

   sext_field #(.IN_W(SEXT9_W), .OUT_W(WORD_W), .SIGNED(1'b1)) uExt9 (
      .field_i (IR[SEXT9_W-1:0]),
      .ext_o   (ext9)
   );

   sext_field #(.IN_W(SEXT11_W), .OUT_W(WORD_W), .SIGNED(1'b1)) uExt11 (
      .field_i (IR[SEXT11_W-1:0]),
      .ext_o   (ext11)
   );

   sext_field #(.IN_W(ZEXT8_W), .OUT_W(WORD_W), .SIGNED(1'b0)) uExt8 (
      .field_i (IR[ZEXT8_W-1:0]),
      .ext_o   (ext8)
   );

   // Handshake outputs come straight from the occupancy register.
   assign OutValid = (state_q != OCC_EMPTY);
   assign InReady  = (state_q != OCC_FULL);
   assign DataOut  = outData_q;
   assign SelErr   = outErr_q;

   assign accept = InValid && InReady;
   assign drain  = OutValid && OutReady;

   // Pick the extended field for this Sel; illegal codes yield zero with the error flag.
   always_comb begin
      newData = '0;
      newErr  = 1'b0;
      case (Sel)
         SEXT5:   newData = ext5;
         SEXT6:   newData = ext6;
         SEXT9:   newData = ext9;
         SEXT11:  newData = ext11;
         ZEXT8:   newData = ext8;
         default: begin
            newData = '0;
            newErr  = 1'b1;
         end
      endcase
   end

   // Occupancy FSM: decide where a new entry lands and when skid refills the output.
   always_comb begin
      state_d    = state_q;
      outData_d  = outData_q;
      outErr_d   = outErr_q;
      skidData_d = skidData_q;
      skidErr_d  = skidErr_q;
      case (state_q)
         OCC_EMPTY: begin
            if (accept) begin
               outData_d = newData;
               outErr_d  = newErr;
               state_d   = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (accept && drain) begin
               outData_d = newData;
               outErr_d  = newErr;
            end else if (accept) begin
               skidData_d = newData;
               skidErr_d  = newErr;
               state_d    = OCC_FULL;
            end else if (drain) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (drain) begin
               outData_d = skidData_q;
               outErr_d  = skidErr_q;
               state_d   = OCC_ONE;
            end
         end
         default: begin
            state_d = OCC_EMPTY;
         end
      endcase
   end

   // State and data registers; reset discards both entries immediately.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= OCC_EMPTY;
         outData_q  <= '0;
         outErr_q   <= 1'b0;
         skidData_q <= '0;
         skidErr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         outData_q  <= outData_d;
         outErr_q   <= outErr_d;
         skidData_q <= skidData_d;
         skidErr_q  <= skidErr_d;
      end
   end

endmodule

// File: tb/tb_sext_pipe.sv
// Self-checking bench for sext_pipe: a queue-based reference model checked on
// every falling edge, plus directed vectors with hand-computed results.
module tb_sext_pipe;
   import sext_pkg::*;

   logic        Clk;
   logic        Reset;
   logic [15:0] IR;
   ext_sel_t    Sel;
   logic        InValid;
   logic        InReady;
   logic [15:0] DataOut;
   logic        OutValid;
   logic        OutReady;
   logic        SelErr;

   int testCount = 0;
   int failCount = 0;

   typedef struct {
      logic [15:0] data;
      logic        err;
   } entry_t;

   entry_t modelQ[$];

   // Directed vectors from the basic and sign-check cases.
   logic [15:0] dirIr  [7] = '{16'h001F, 16'h000F, 16'h0100, 16'h0400, 16'h0020, 16'h00FF, 16'hFFFF};
   logic [2:0]  dirSel [7] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd1, 3'd4, 3'd6};
   logic [15:0] dirData[7] = '{16'hFFFF, 16'h000F, 16'hFF00, 16'hFC00, 16'hFFE0, 16'h00FF, 16'h0000};
   logic        dirErr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   // Streaming vectors, including upper IR bits that must be ignored.
   logic [15:0] strIr  [8] = '{16'h0010, 16'hFFE5, 16'h003F, 16'h001F, 16'h01FF, 16'h00FF, 16'h07FF, 16'hF080};
   logic [2:0]  strSel [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
   logic [15:0] strData[8] = '{16'hFFF0, 16'h0005, 16'hFFFF, 16'h001F, 16'hFFFF, 16'h00FF, 16'hFFFF, 16'h0080};

   sext_pipe #(.WORD_W(16), .IR_W(16)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .IR       (IR),
      .Sel      (Sel),
      .InValid  (InValid),
      .InReady  (InReady),
      .DataOut  (DataOut),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .SelErr   (SelErr)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Arithmetic reference: mask the field, subtract 2^w when signed and negative.
   function automatic entry_t modelExt(input logic [15:0] ir, input int code);
      entry_t e;
      int     w;
      bit     isSigned;
      int     field;
      e.data   = 16'h0000;
      e.err    = 1'b0;
      w        = 0;
      isSigned = 1'b1;
      case (code)
         0: w = 5;
         1: w = 6;
         2: w = 9;
         3: w = 11;
         4: begin
            w = 8;
            isSigned = 1'b0;
         end
         default: e.err = 1'b1;
      endcase
      if (!e.err) begin
         field = int'(ir) & ((1 << w) - 1);
         if (isSigned && field >= (1 << (w - 1)))
            field = field - (1 << w);
         e.data = 16'(field);
      end
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] ir, input logic [2:0] sel);
      IR      = ir;
      Sel     = ext_sel_t'(sel);
      InValid = 1'b1;
      @(posedge Clk);
      #1;
      InValid = 1'b0;
   endtask

   // Compare DUT against the model each falling edge, then advance the model.
   always @(negedge Clk) begin : cmpProc
      bit acc;
      if (Reset) begin
         modelQ.delete();
         checkOutput("rstOutValid", 32'(OutValid), 32'h0);
         checkOutput("rstInReady", 32'(InReady), 32'h1);
         checkOutput("rstDataOut", 32'(DataOut), 32'h0);
         checkOutput("rstSelErr", 32'(SelErr), 32'h0);
      end else begin
         checkOutput("cmpInReady", 32'(InReady), 32'(modelQ.size() < 2));
         checkOutput("cmpOutValid", 32'(OutValid), 32'(modelQ.size() > 0));
         if (modelQ.size() > 0) begin
            checkOutput("cmpDataOut", 32'(DataOut), 32'(modelQ[0].data));
            checkOutput("cmpSelErr", 32'(SelErr), 32'(modelQ[0].err));
         end
         acc = InValid && (modelQ.size() < 2);
         if (OutReady && modelQ.size() > 0)
            modelQ.pop_front();
         if (acc)
            modelQ.push_back(modelExt(IR, int'(Sel)));
      end
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin : mainSeq
      entry_t pin;
      Reset    = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b1;
      IR       = 16'h0000;
      Sel      = SEXT5;

      #2 Reset = 1'b1;
      #1;
      checkOutput("resetInReady", 32'(InReady), 32'h1);
      checkOutput("resetOutValid", 32'(OutValid), 32'h0);
      checkOutput("resetDataOut", 32'(DataOut), 32'h0);
      checkOutput("resetSelErr", 32'(SelErr), 32'h0);
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;

      pin = modelExt(16'h001F, 0);
      checkOutput("pinSext5", 32'(pin.data), 32'hFFFF);
      pin = modelExt(16'h0020, 1);
      checkOutput("pinSext6", 32'(pin.data), 32'hFFE0);
      pin = modelExt(16'h0400, 3);
      checkOutput("pinSext11", 32'(pin.data), 32'hFC00);
      pin = modelExt(16'h00FF, 4);
      checkOutput("pinZext8", 32'(pin.data), 32'h00FF);
      pin = modelExt(16'hFFFF, 6);
      checkOutput("pinIllegal", {15'h0, pin.err, pin.data}, 32'h0001_0000);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(dirIr[i], dirSel[i]);
         checkOutput($sformatf("dirData%0d", i), 32'(DataOut), 32'(dirData[i]));
         checkOutput($sformatf("dirErr%0d", i), 32'(SelErr), 32'(dirErr[i]));
         checkOutput($sformatf("dirValid%0d", i), 32'(OutValid), 32'h1);
      end
      @(posedge Clk);
      #1;
      checkOutput("idleOutValid", 32'(OutValid), 32'h0);

      OutReady = 1'b0;
      applyStimulus(16'h0011, 3'd0);
      checkOutput("bpAData", 32'(DataOut), 32'hFFF1);
      checkOutput("bpAInReady", 32'(InReady), 32'h1);
      applyStimulus(16'h0001, 3'd0);
      checkOutput("bpFullInReady", 32'(InReady), 32'h0);
      checkOutput("bpHeldData", 32'(DataOut), 32'hFFF1);
      @(posedge Clk);
      #1;
      checkOutput("bpStillHeld", 32'(DataOut), 32'hFFF1);
      checkOutput("bpStillFull", 32'(InReady), 32'h0);
      OutReady = 1'b1;
      @(posedge Clk);
      #1;
      checkOutput("bpBData", 32'(DataOut), 32'h0001);
      checkOutput("bpBValid", 32'(OutValid), 32'h1);
      checkOutput("bpReadyBack", 32'(InReady), 32'h1);
      @(posedge Clk);
      #1;
      checkOutput("bpDrained", 32'(OutValid), 32'h0);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(strIr[i], strSel[i]);
         checkOutput($sformatf("strData%0d", i), 32'(DataOut), 32'(strData[i]));
         checkOutput($sformatf("strValid%0d", i), 32'(OutValid), 32'h1);
      end
      @(posedge Clk);
      #1;
      checkOutput("strIdle", 32'(OutValid), 32'h0);

      OutReady = 1'b0;
      applyStimulus(16'h0005, 3'd0);
      applyStimulus(16'h0006, 3'd0);
      checkOutput("rfFull", 32'(InReady), 32'h0);
      IR      = 16'h001F;
      Sel     = SEXT5;
      InValid = 1'b1;
      #1 Reset = 1'b1;
      #1;
      checkOutput("rfAsyncOutValid", 32'(OutValid), 32'h0);
      checkOutput("rfAsyncInReady", 32'(InReady), 32'h1);
      checkOutput("rfAsyncDataOut", 32'(DataOut), 32'h0);
      @(posedge Clk);
      #1;
      Reset    = 1'b0;
      InValid  = 1'b0;
      OutReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk);
         #1;
         checkOutput($sformatf("rfNoStale%0d", i), 32'(OutValid), 32'h0);
      end
      applyStimulus(16'h000F, 3'd0);
      checkOutput("rfRecover", 32'(DataOut), 32'h000F);

      @(posedge Clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
